inv_key_schedule: RTL



---
 rtl/inv_key_schedule.sv | 129 ++++++++++++
 1 files changed

// File: rtl/inv_key_schedule.sv
// inv_key_schedule: iterative AES-128 decryption key schedule, emits round keys 10 down to 0 over a valid/ready handshake.
module inv_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         key_is_last,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("inv_key_schedule supports NUM_ROUNDS=10 only");
  end
  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;
  state_t       r_state;
  logic [127:0] r_key;
  logic [3:0]   r_cnt, r_round;
  logic         r_valid, r_busy, r_done;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_i1, w_i2, w_i3, w_n0, w_f1, w_f2, w_f3, w_sub_in, w_sub;
  logic [3:0]   w_rsel;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // S-box built from x^254 (GF inverse, 0 maps to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, r;
    y = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      y = gmul(y, y);
      r = gmul(r, y);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_i3 = w_w3 ^ w_w2;
  assign w_i2 = w_w2 ^ w_w1;
  assign w_i1 = w_w1 ^ w_w0;
  // one SubWord shared by both directions: forward uses w3, inverse uses the recovered w3
  assign w_rsel   = (r_state == FWD) ? r_cnt : r_round;
  assign w_sub_in = (r_state == FWD) ? w_w3 : w_i3;
  assign w_sub    = {sbox(w_sub_in[23:16]), sbox(w_sub_in[15:8]), sbox(w_sub_in[7:0]), sbox(w_sub_in[31:24])}
                    ^ {rcon(w_rsel), 24'h0};
  assign w_n0 = w_w0 ^ w_sub;
  assign w_f1 = w_w1 ^ w_n0;
  assign w_f2 = w_w2 ^ w_f1;
  assign w_f3 = w_w3 ^ w_f2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_cnt   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_key   <= key_in;
          r_busy  <= 1'b1;
          r_state <= key_is_last ? EMIT : FWD;
          r_valid <= key_is_last;
          r_round <= key_is_last ? LAST : r_round;
          r_cnt   <= 4'd1;
        end
        FWD: begin
          r_key <= {w_n0, w_f1, w_f2, w_f3};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST) begin
            r_state <= EMIT;
            r_round <= LAST;
            r_valid <= 1'b1;
          end
        end
        EMIT: if (rk_ready) begin
          if (r_round == 4'd0) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_key   <= {w_n0, w_i1, w_i2, w_i3};
            r_round <= r_round - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy     = r_busy;
  assign rk_valid = r_valid;
  assign rk_out   = r_key;
  assign rk_round = r_round;
  assign done     = r_done;
endmodule
